// File: rtl/csr_exec_unit.sv
// CSR/system instruction sequencer: IDLE -> READ -> EXEC -> DONE, one op in flight.
// Optional read-only-space write check enabled by defining CSR_ILLEGAL_CHECK_EN.
module csr_exec_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [2:0]      in_funct3,
  input  logic [11:0]     in_csr_addr,
  input  logic [4:0]      in_rs1,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [4:0]      in_rd,
  input  logic            in_is_ecall,
  input  logic            in_is_mret,
  output logic [11:0]     csr_addr_read,
  input  logic [XLEN-1:0] csr_rdata,
  output logic [11:0]     csr_addr_write,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_we,
  output logic            csr_is_ecall,
  output logic            csr_is_mret,
  output logic [XLEN-1:0] csr_pc,
  input  logic [XLEN-1:0] csr_next_pc,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            illegal,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_DONE} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc, r_rs1_val, r_old, r_wdata, r_redirect_pc;
  logic [2:0]      r_funct3;
  logic [11:0]     r_addr;
  logic [4:0]      r_rs1, r_rd;
  logic            r_ecall, r_mret;
  logic            r_we, r_trap_e, r_trap_m, r_wb_valid, r_redirect, r_illegal;

  logic            w_is_ecall, w_is_mret, w_is_csr, w_wen, w_illegal;
  logic [XLEN-1:0] w_src, w_new;

  // ECALL wins over MRET, and either wins over the funct3 decode.
  assign w_is_ecall = r_ecall;
  assign w_is_mret  = r_mret & ~r_ecall;
  assign w_is_csr   = ~r_ecall & ~r_mret & (r_funct3[1:0] != 2'b00);
  assign w_src      = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1} : r_rs1_val;
  assign w_wen      = w_is_csr & ((r_funct3[1:0] == 2'b01) | (r_rs1 != 5'd0));

  always_comb begin
    w_new = w_src;
    case (r_funct3[1:0])
      2'b10:   w_new = csr_rdata | w_src;
      2'b11:   w_new = csr_rdata & ~w_src;
      default: w_new = w_src;
    endcase
  end

`ifdef CSR_ILLEGAL_CHECK_EN
  assign w_illegal = w_wen & (r_addr[11:10] == 2'b11);
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_rs1_val     <= '0;
      r_old         <= '0;
      r_wdata       <= '0;
      r_redirect_pc <= '0;
      r_funct3      <= '0;
      r_addr        <= '0;
      r_rs1         <= '0;
      r_rd          <= '0;
      r_ecall       <= 1'b0;
      r_mret        <= 1'b0;
      r_we          <= 1'b0;
      r_trap_e      <= 1'b0;
      r_trap_m      <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_redirect    <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_trap_e   <= 1'b0;
      r_trap_m   <= 1'b0;
      r_wb_valid <= 1'b0;
      r_redirect <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_pc      <= in_pc;
          r_funct3  <= in_funct3;
          r_addr    <= in_csr_addr;
          r_rs1     <= in_rs1;
          r_rs1_val <= in_rs1_val;
          r_rd      <= in_rd;
          r_ecall   <= in_is_ecall;
          r_mret    <= in_is_mret;
          r_state   <= S_READ;
        end
        // Strobes for EXEC are registered here so they appear as clean pulses.
        S_READ: begin
          r_old    <= csr_rdata;
          r_wdata  <= w_new;
          r_we     <= w_wen & ~w_illegal;
          r_trap_e <= w_is_ecall;
          r_trap_m <= w_is_mret;
          r_state  <= S_EXEC;
        end
        // Trap target is sampled before the CSR file commits the trap at this edge.
        S_EXEC: begin
          r_redirect    <= 1'b1;
          r_redirect_pc <= (w_is_ecall | w_is_mret) ? csr_next_pc : r_pc + XLEN'(4);
          r_wb_valid    <= w_is_csr & (r_rd != 5'd0) & ~w_illegal;
          r_illegal     <= w_illegal;
          r_state       <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pulses are masked by reset so an aborted op never reaches the CSR file.
  assign in_ready       = (r_state == S_IDLE) & ~reset;
  assign busy           = (r_state != S_IDLE) & ~reset;
  assign csr_we         = r_we & ~reset;
  assign csr_is_ecall   = r_trap_e & ~reset;
  assign csr_is_mret    = r_trap_m & ~reset;
  assign wb_valid       = r_wb_valid & ~reset;
  assign redirect_valid = r_redirect & ~reset;
  assign flush          = r_redirect & ~reset;
  assign illegal        = r_illegal & ~reset;

  assign csr_addr_read  = r_addr;
  assign csr_addr_write = r_addr;
  assign csr_wdata      = r_wdata;
  assign csr_pc         = r_pc;
  assign wb_rd          = r_rd;
  assign wb_data        = r_old;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit: directed ops push expected EXEC/DONE events,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_csr_exec_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] in_pc, in_rs1_val;
  logic [2:0]  in_funct3;
  logic [11:0] in_csr_addr;
  logic [4:0]  in_rs1, in_rd;
  logic        in_is_ecall, in_is_mret;
  logic [11:0] csr_addr_read, csr_addr_write;
  logic [63:0] csr_rdata, csr_wdata, csr_pc, csr_next_pc;
  logic        csr_we, csr_is_ecall, csr_is_mret;
  logic        wb_valid, redirect_valid, flush, illegal, busy;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data, redirect_pc;

  csr_exec_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_funct3(in_funct3), .in_csr_addr(in_csr_addr), .in_rs1(in_rs1), .in_rs1_val(in_rs1_val),
    .in_rd(in_rd), .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret),
    .csr_addr_read(csr_addr_read), .csr_rdata(csr_rdata), .csr_addr_write(csr_addr_write),
    .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_is_ecall(csr_is_ecall), .csr_is_mret(csr_is_mret),
    .csr_pc(csr_pc), .csr_next_pc(csr_next_pc), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Static CSR file contents (responder only) and fixed trap targets.
  always_comb begin
    case (csr_addr_read)
      12'h340: csr_rdata = 64'h1234;
      12'h300: csr_rdata = 64'h1888;
      12'h305: csr_rdata = 64'h10;
      12'h341: csr_rdata = 64'h77;
      12'h306: csr_rdata = '1;
      12'hF14: csr_rdata = 64'h7;
      default: csr_rdata = 64'h0;
    endcase
  end
  assign csr_next_pc = csr_is_ecall ? 64'h8000_1000 : (csr_is_mret ? 64'h8000_0014 : 64'h0);

  typedef struct {int t; logic we, ec, mr; logic [11:0] addr; logic [63:0] wdata, pc;} exec_t;
  typedef struct {int t; logic wb; logic [4:0] rd; logic [63:0] data, rpc; logic ill;} done_t;
  exec_t eq[$];
  done_t dq[$];
  exec_t me;
  done_t md;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (csr_we | csr_is_ecall | csr_is_mret) begin
        if (eq.size() == 0) chk("exec_unexpected_strobe", 64'(1), 64'(0));
        else begin
          me = eq.pop_front();
          chk("exec_cycle", 64'(cyc), 64'(me.t + 2));
          chk("exec_we", 64'(csr_we), 64'(me.we));
          chk("exec_ecall", 64'(csr_is_ecall), 64'(me.ec));
          chk("exec_mret", 64'(csr_is_mret), 64'(me.mr));
          if (me.we) begin
            chk("exec_waddr", 64'(csr_addr_write), 64'(me.addr));
            chk("exec_wdata", csr_wdata, me.wdata);
          end
          if (me.ec | me.mr) chk("exec_csr_pc", csr_pc, me.pc);
        end
      end
      if (redirect_valid) begin
        if (dq.size() == 0) chk("done_unexpected_redirect", 64'(1), 64'(0));
        else begin
          md = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(md.t + 3));
          chk("done_flush", 64'(flush), 64'(1));
          chk("done_wb_valid", 64'(wb_valid), 64'(md.wb));
          if (md.wb) begin
            chk("done_wb_rd", 64'(wb_rd), 64'(md.rd));
            chk("done_wb_data", wb_data, md.data);
          end
          chk("done_redirect_pc", redirect_pc, md.rpc);
          chk("done_illegal", 64'(illegal), 64'(md.ill));
        end
      end else if (wb_valid | flush | illegal) begin
        chk("stray_done_pulse", 64'({wb_valid, flush, illegal}), 64'(0));
      end
    end
  end

  // Holds in_valid until accepted; returns one cycle after acceptance with in_valid still high.
  task automatic issue(input logic [63:0] pc, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [4:0] rs1, input logic [63:0] v, input logic [4:0] rd,
                       input logic ec, input logic mr, input logic ewe, input logic [63:0] ewd,
                       input logic ewb, input logic [63:0] ewbd, input logic [63:0] erpc,
                       input logic eill, input bit push, output int t);
    int n;
    exec_t e;
    done_t d;
    @(negedge clk);
    in_pc = pc; in_funct3 = f3; in_csr_addr = addr; in_rs1 = rs1; in_rs1_val = v;
    in_rd = rd; in_is_ecall = ec; in_is_mret = mr; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'(1));
      t = -100;
      return;
    end
    t = cyc;
    if (push) begin
      if (ewe | ec | mr) begin
        e.t = t; e.we = ewe; e.ec = ec; e.mr = mr & ~ec; e.addr = addr; e.wdata = ewd; e.pc = pc;
        eq.push_back(e);
      end
      d.t = t; d.wb = ewb; d.rd = rd; d.data = ewbd; d.rpc = erpc; d.ill = eill;
      dq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  int t1, t2, tx;
  logic        ro_we, ro_wb, ro_ill;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_funct3 = '0; in_csr_addr = '0;
    in_rs1 = '0; in_rs1_val = '0; in_rd = '0; in_is_ecall = 1'b0; in_is_mret = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pulses", 64'({csr_we, csr_is_ecall, csr_is_mret, wb_valid, redirect_valid, flush, illegal}), 64'(0));
    chk("rst_wb_data", wb_data, 64'h0);
    chk("rst_csr_wdata", csr_wdata, 64'h0);
    chk("rst_redirect_pc", redirect_pc, 64'h0);

    // CSRRW then CSRRS x0 back to back: second is held off until T+4.
    issue(64'h1000, 3'b001, 12'h340, 5'd3, 64'hDEAD_BEEF, 5'd5, 0, 0, 1, 64'hDEAD_BEEF, 1, 64'h1234, 64'h1004, 0, 1, t1);
    issue(64'h1004, 3'b010, 12'h300, 5'd0, 64'hFFFF, 5'd6, 0, 0, 0, 64'h0, 1, 64'h1888, 64'h1008, 0, 1, t2);
    chk("b2b_accept_gap", 64'(t2 - t1), 64'(4));
    issue(64'h1008, 3'b011, 12'h300, 5'd2, 64'h8, 5'd7, 0, 0, 1, 64'h1880, 1, 64'h1888, 64'h100C, 0, 1, tx);
    issue(64'h100C, 3'b110, 12'h305, 5'd5, 64'hFFFF_0000, 5'd8, 0, 0, 1, 64'h15, 1, 64'h10, 64'h1010, 0, 1, tx);
    issue(64'h1010, 3'b101, 12'h341, 5'd0, 64'h99, 5'd0, 0, 0, 1, 64'h0, 0, 64'h0, 64'h1014, 0, 1, tx);
    issue(64'h1014, 3'b111, 12'h306, 5'd31, 64'h0, 5'd1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFE0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1018, 0, 1, tx);
    // Traps, including priority over funct3 and ECALL over MRET.
    issue(64'h8000_0010, 3'b000, 12'h000, 5'd0, 64'h0, 5'd0, 1, 0, 0, 64'h0, 0, 64'h0, 64'h8000_1000, 0, 1, tx);
    issue(64'h8000_1040, 3'b001, 12'h340, 5'd3, 64'h5, 5'd3, 0, 1, 0, 64'h0, 0, 64'h0, 64'h8000_0014, 0, 1, tx);
    issue(64'h3000, 3'b010, 12'h300, 5'd1, 64'h1, 5'd4, 1, 1, 0, 64'h0, 0, 64'h0, 64'h8000_1000, 0, 1, tx);
    // Non-CSR funct3 and PC wraparound.
    issue(64'h2000, 3'b100, 12'h340, 5'd3, 64'h1, 5'd9, 0, 0, 0, 64'h0, 0, 64'h0, 64'h2004, 0, 1, tx);
    issue(64'hFFFF_FFFF_FFFF_FFFC, 3'b000, 12'h340, 5'd3, 64'h1, 5'd9, 0, 0, 0, 64'h0, 0, 64'h0, 64'h0, 0, 1, tx);
    // Read-only space.
`ifdef CSR_ILLEGAL_CHECK_EN
    ro_we = 1'b0; ro_wb = 1'b0; ro_ill = 1'b1;
`else
    ro_we = 1'b1; ro_wb = 1'b1; ro_ill = 1'b0;
`endif
    issue(64'h4000, 3'b001, 12'hF14, 5'd3, 64'h55, 5'd4, 0, 0, ro_we, 64'h55, ro_wb, 64'h7, 64'h4004, ro_ill, 1, tx);
    issue(64'h4004, 3'b010, 12'hF14, 5'd0, 64'h55, 5'd4, 0, 0, 0, 64'h0, 1, 64'h7, 64'h4008, 0, 1, tx);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("exec_queue_drained", 64'(eq.size()), 64'(0));
    chk("done_queue_drained", 64'(dq.size()), 64'(0));

    // Reset during EXEC aborts the op without any strobe.
    issue(64'h5000, 3'b001, 12'h340, 5'd3, 64'hABCD, 5'd5, 0, 0, 1, 64'hABCD, 1, 64'h1234, 64'h5004, 0, 0, tx);
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_cycle_is_exec", 64'(cyc), 64'(tx + 2));
    chk("midrst_no_we", 64'(csr_we), 64'(0));
    chk("midrst_no_trap", 64'({csr_is_ecall, csr_is_mret}), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_wdata_cleared", csr_wdata, 64'h0);
    chk("midrst_wb_data_cleared", wb_data, 64'h0);
    repeat (4) @(negedge clk);
    chk("midrst_no_redirect", 64'(dq.size() + eq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
